// File: rtl/rob_commit_ctrl_pkg.sv
// Shared types for the ROB head retirement controller: tag/data widths, head kinds, FSM states.
package rob_commit_ctrl_pkg;

    localparam int unsigned RobIdW = 5;
    localparam int unsigned LsIdW  = 3;
    localparam int unsigned RegW   = 32;

    typedef logic [RobIdW-1:0] rob_id_t;
    typedef logic [LsIdW-1:0]  ls_id_t;
    typedef logic [RegW-1:0]   reg_t;
    typedef logic [4:0]        reg_idx_t;

    typedef enum logic [1:0] {
        KindNormal = 2'b00,
        KindBranch = 2'b01,
        KindStore  = 2'b10,
        KindHalt   = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        StIdle      = 2'b00,
        StWaitStore = 2'b01,
        StFlush     = 2'b10,
        StHalted    = 2'b11
    } state_e;

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Head-entry, commit, flush and store-issue signals between the ROB and its retirement controller.
interface rob_commit_ctrl_if #(
    parameter int unsigned CntW = 32
);
    import rob_commit_ctrl_pkg::*;

    logic            head_valid;
    logic            head_ready;
    kind_e           head_kind;
    rob_id_t         head_rob_id;
    reg_idx_t        head_rd;
    reg_t            head_value;
    logic            head_mispredict;
    reg_t            head_target_pc;
    ls_id_t          head_ls_id;
    logic            store_done;

    logic            pop_head;
    logic            commit_valid;
    reg_idx_t        commit_rd;
    reg_t            commit_value;
    rob_id_t         commit_rob_id;
    logic            reset_out;
    reg_t            pc_out;
    logic            store_valid;
    ls_id_t          store_id;
    logic            halted;
    logic [CntW-1:0] retired_cnt;

    // ROB side
    modport master (
        output head_valid, head_ready, head_kind, head_rob_id, head_rd, head_value,
               head_mispredict, head_target_pc, head_ls_id, store_done,
        input  pop_head, commit_valid, commit_rd, commit_value, commit_rob_id,
               reset_out, pc_out, store_valid, store_id, halted, retired_cnt
    );

    // Retirement controller side
    modport slave (
        input  head_valid, head_ready, head_kind, head_rob_id, head_rd, head_value,
               head_mispredict, head_target_pc, head_ls_id, store_done,
        output pop_head, commit_valid, commit_rd, commit_value, commit_rob_id,
               reset_out, pc_out, store_valid, store_id, halted, retired_cnt
    );

endinterface

// File: rtl/rob_commit_ctrl.sv
// Head-of-ROB retirement FSM: one retire per cycle, store serialisation against ls_buffer,
// one-cycle flush/redirect on branch mispredict, sticky halt.
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic               clk,
    input logic               rst,
    rob_commit_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntOne = 1;

    state_e            state_q, state_d;
    logic              pop;
    logic              fire;
    logic              commit_valid_q, commit_valid_d;
    reg_idx_t          commit_rd_q, commit_rd_d;
    reg_t              commit_value_q, commit_value_d;
    rob_id_t           commit_rob_id_q, commit_rob_id_d;
    logic              reset_out_q, reset_out_d;
    reg_t              pc_out_q, pc_out_d;
    logic              store_valid_q, store_valid_d;
    ls_id_t            store_id_q, store_id_d;
    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        state_d         = state_q;
        pop             = 1'b0;
        commit_valid_d  = 1'b0;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;
        commit_rob_id_d = commit_rob_id_q;
        reset_out_d     = 1'b0;
        pc_out_d        = pc_out_q;
        store_valid_d   = 1'b0;
        store_id_d      = store_id_q;
        halted_d        = halted_q;
        cnt_d           = cnt_q;
        fire            = bus.head_valid & bus.head_ready;

        unique case (state_q)
            StIdle: begin
                if (fire) begin
                    unique case (bus.head_kind)
                        KindNormal, KindBranch: begin
                            pop             = 1'b1;
                            commit_valid_d  = (bus.head_rd != 5'd0);
                            commit_rd_d     = bus.head_rd;
                            commit_value_d  = bus.head_value;
                            commit_rob_id_d = bus.head_rob_id;
                            cnt_d           = cnt_q + CntOne;
                            if (bus.head_kind == KindBranch && bus.head_mispredict) begin
                                reset_out_d = 1'b1;
                                pc_out_d    = bus.head_target_pc;
                                state_d     = StFlush;
                            end
                        end
                        // Store stays at the head until ls_buffer reports completion.
                        KindStore: begin
                            store_valid_d = 1'b1;
                            store_id_d    = bus.head_ls_id;
                            state_d       = StWaitStore;
                        end
                        KindHalt: begin
                            pop      = 1'b1;
                            cnt_d    = cnt_q + CntOne;
                            halted_d = 1'b1;
                            state_d  = StHalted;
                        end
                        default: ;
                    endcase
                end
            end
            StWaitStore: begin
                if (bus.store_done) begin
                    pop     = 1'b1;
                    cnt_d   = cnt_q + CntOne;
                    state_d = StIdle;
                end
            end
            StFlush:  state_d = StIdle;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            commit_valid_q  <= 1'b0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            commit_rob_id_q <= '0;
            reset_out_q     <= 1'b0;
            pc_out_q        <= '0;
            store_valid_q   <= 1'b0;
            store_id_q      <= '0;
            halted_q        <= 1'b0;
            cnt_q           <= '0;
        end else begin
            state_q         <= state_d;
            commit_valid_q  <= commit_valid_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            commit_rob_id_q <= commit_rob_id_d;
            reset_out_q     <= reset_out_d;
            pc_out_q        <= pc_out_d;
            store_valid_q   <= store_valid_d;
            store_id_q      <= store_id_d;
            halted_q        <= halted_d;
            cnt_q           <= cnt_d;
        end
    end

    // Reset wins over an in-flight pop so the ROB never advances during reset.
    assign bus.pop_head      = pop & ~rst;
    assign bus.commit_valid  = commit_valid_q;
    assign bus.commit_rd     = commit_rd_q;
    assign bus.commit_value  = commit_value_q;
    assign bus.commit_rob_id = commit_rob_id_q;
    assign bus.reset_out     = reset_out_q;
    assign bus.pc_out        = pc_out_q;
    assign bus.store_valid   = store_valid_q;
    assign bus.store_id      = store_id_q;
    assign bus.halted        = halted_q;
    assign bus.retired_cnt   = cnt_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed scenarios plus randomized traffic against a retirement model.
module tb_rob_commit_ctrl;
    import rob_commit_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rob_commit_ctrl_if #(.CntW(32)) bus ();
    rob_commit_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: what the ROB head controller has promised, in terms of visible events only.
    bit          m_store_wait;
    bit          e_halted;
    logic [31:0] m_cnt;
    bit          e_cv;
    reg_idx_t    e_rd;
    reg_t        e_val;
    rob_id_t     e_rid;
    bit          e_ro;
    reg_t        e_pc;
    bit          e_sv;
    ls_id_t      e_sid;

    function automatic bit model_pop();
        if (rst || e_halted) return 1'b0;
        if (m_store_wait) return bus.store_done;
        if (e_ro) return 1'b0;
        return bus.head_valid && bus.head_ready && bus.head_kind != KindStore;
    endfunction

    task automatic model_edge();
        bit acc;
        if (rst) begin
            m_store_wait = 0; e_halted = 0; m_cnt = 0; e_cv = 0; e_rd = 0; e_val = 0;
            e_rid = 0; e_ro = 0; e_pc = 0; e_sv = 0; e_sid = 0;
            return;
        end
        acc = !e_halted && !m_store_wait && !e_ro && bus.head_valid && bus.head_ready;
        e_cv = 0; e_ro = 0; e_sv = 0;
        if (m_store_wait) begin
            if (bus.store_done) begin
                m_store_wait = 0;
                m_cnt = m_cnt + 1;
            end
        end else if (acc) begin
            case (bus.head_kind)
                KindNormal, KindBranch: begin
                    e_cv  = (bus.head_rd != 0);
                    e_rd  = bus.head_rd;
                    e_val = bus.head_value;
                    e_rid = bus.head_rob_id;
                    m_cnt = m_cnt + 1;
                    if (bus.head_kind == KindBranch && bus.head_mispredict) begin
                        e_ro = 1;
                        e_pc = bus.head_target_pc;
                    end
                end
                KindStore: begin
                    e_sv = 1;
                    e_sid = bus.head_ls_id;
                    m_store_wait = 1;
                end
                default: begin
                    m_cnt = m_cnt + 1;
                    e_halted = 1;
                end
            endcase
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_head(input bit v, input bit r, input kind_e k, input logic [4:0] rd,
                            input reg_t val, input bit mis, input reg_t tgt, input ls_id_t ls);
        bus.head_valid      = v;
        bus.head_ready      = r;
        bus.head_kind       = k;
        bus.head_rob_id     = rob_id_t'($urandom);
        bus.head_rd         = rd;
        bus.head_value      = val;
        bus.head_mispredict = mis;
        bus.head_target_pc  = tgt;
        bus.head_ls_id      = ls;
    endtask

    task automatic idle_head();
        set_head(0, 0, KindNormal, 0, 0, 0, 0, 0);
        bus.store_done = 0;
    endtask

    task automatic test_reset();
        idle_head();
        bus.store_done = 1;
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        n_cmp += 10;
        if (bus.pop_head !== 1'b0) begin
            n_fail++; $display("FAIL reset_pop got=%0b want=0", bus.pop_head);
        end
        if (bus.commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_cv got=%0b want=0", bus.commit_valid);
        end
        if (bus.reset_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_ro got=%0b want=0", bus.reset_out);
        end
        if (bus.store_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_sv got=%0b want=0", bus.store_valid);
        end
        if (bus.halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_halted got=%0b want=0", bus.halted);
        end
        if (bus.retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt got=%0d want=0", bus.retired_cnt);
        end
        if (bus.commit_rd !== 5'd0) begin
            n_fail++; $display("FAIL reset_rd got=%0d want=0", bus.commit_rd);
        end
        if (bus.commit_value !== '0) begin
            n_fail++; $display("FAIL reset_value got=%0h want=0", bus.commit_value);
        end
        if (bus.pc_out !== '0) begin
            n_fail++; $display("FAIL reset_pc got=%0h want=0", bus.pc_out);
        end
        if (bus.store_id !== '0) begin
            n_fail++; $display("FAIL reset_sid got=%0d want=0", bus.store_id);
        end
        bus.store_done = 0;
        #1;
    endtask

    task automatic test_back_to_back();
        reg_t vals[4];
        for (int i = 0; i < 4; i++) begin
            vals[i] = reg_t'($urandom);
            set_head(1, 1, KindNormal, 5'(i + 1), vals[i], 0, 0, 0);
            #1;
            n_cmp++;
            if (bus.pop_head !== 1'b1) begin
                n_fail++; $display("FAIL b2b_pop[%0d] got=%0b want=1", i, bus.pop_head);
            end
            tick();
            n_cmp++;
            if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'(i + 1) ||
                bus.commit_value !== vals[i]) begin
                n_fail++;
                $display("FAIL b2b_commit[%0d] got=%0b/%0d/%0h want=1/%0d/%0h", i,
                         bus.commit_valid, bus.commit_rd, bus.commit_value, i + 1, vals[i]);
            end
        end
        idle_head();
        n_cmp++;
        if (bus.retired_cnt !== 32'd4) begin
            n_fail++; $display("FAIL b2b_cnt got=%0d want=4", bus.retired_cnt);
        end
        tick();
        n_cmp++;
        if (bus.commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_cv_drop got=%0b want=0", bus.commit_valid);
        end
    endtask

    task automatic test_rd_zero();
        logic [31:0] c0;
        c0 = bus.retired_cnt;
        set_head(1, 1, KindNormal, 0, 32'hdead_beef, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.pop_head !== 1'b1) begin
            n_fail++; $display("FAIL rd0_pop got=%0b want=1", bus.pop_head);
        end
        tick();
        idle_head();
        n_cmp += 2;
        if (bus.commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL rd0_cv got=%0b want=0", bus.commit_valid);
        end
        if (bus.retired_cnt !== c0 + 1) begin
            n_fail++; $display("FAIL rd0_cnt got=%0d want=%0d", bus.retired_cnt, c0 + 1);
        end
    endtask

    task automatic test_mispredict();
        set_head(1, 1, KindBranch, 5'd7, 32'h44, 1, 32'h1000, 0);
        #1;
        n_cmp++;
        if (bus.pop_head !== 1'b1) begin
            n_fail++; $display("FAIL mis_pop got=%0b want=1", bus.pop_head);
        end
        tick();
        n_cmp += 2;
        if (bus.reset_out !== 1'b1 || bus.pc_out !== 32'h1000) begin
            n_fail++;
            $display("FAIL mis_flush got=%0b/%0h want=1/1000", bus.reset_out, bus.pc_out);
        end
        if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd7) begin
            n_fail++;
            $display("FAIL mis_link got=%0b/%0d want=1/7", bus.commit_valid, bus.commit_rd);
        end
        set_head(1, 1, KindNormal, 5'd3, 32'h55, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.pop_head !== 1'b0) begin
            n_fail++; $display("FAIL mis_ignore got=%0b want=0", bus.pop_head);
        end
        tick();
        n_cmp++;
        if (bus.reset_out !== 1'b0 || bus.commit_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mis_pulse got=%0b/%0b want=0/0", bus.reset_out, bus.commit_valid);
        end
        #1;
        n_cmp++;
        if (bus.pop_head !== 1'b1) begin
            n_fail++; $display("FAIL mis_resume got=%0b want=1", bus.pop_head);
        end
        tick();
        idle_head();
    endtask

    task automatic test_store();
        logic [31:0] c0;
        c0 = bus.retired_cnt;
        set_head(1, 1, KindStore, 0, 0, 0, 0, 3'd3);
        #1;
        n_cmp++;
        if (bus.pop_head !== 1'b0) begin
            n_fail++; $display("FAIL st_nopop got=%0b want=0", bus.pop_head);
        end
        tick();
        n_cmp++;
        if (bus.store_valid !== 1'b1 || bus.store_id !== 3'd3) begin
            n_fail++;
            $display("FAIL st_issue got=%0b/%0d want=1/3", bus.store_valid, bus.store_id);
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if (bus.pop_head !== 1'b0) begin
                n_fail++; $display("FAIL st_wait_pop[%0d] got=%0b want=0", i, bus.pop_head);
            end
            tick();
            n_cmp++;
            if (bus.store_valid !== 1'b0) begin
                n_fail++; $display("FAIL st_pulse[%0d] got=%0b want=0", i, bus.store_valid);
            end
        end
        bus.store_done = 1;
        #1;
        n_cmp++;
        if (bus.pop_head !== 1'b1) begin
            n_fail++; $display("FAIL st_done_pop got=%0b want=1", bus.pop_head);
        end
        tick();
        idle_head();
        n_cmp += 2;
        if (bus.retired_cnt !== c0 + 1) begin
            n_fail++; $display("FAIL st_cnt got=%0d want=%0d", bus.retired_cnt, c0 + 1);
        end
        if (bus.commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL st_nocommit got=%0b want=0", bus.commit_valid);
        end
        bus.store_done = 1;
        #1;
        n_cmp++;
        if (bus.pop_head !== 1'b0) begin
            n_fail++; $display("FAIL st_stray_done got=%0b want=0", bus.pop_head);
        end
        tick();
        bus.store_done = 0;
    endtask

    task automatic test_reset_in_wait();
        set_head(1, 1, KindStore, 0, 0, 0, 0, 3'd5);
        tick();
        idle_head();
        rst = 1;
        tick();
        rst = 0;
        n_cmp += 2;
        if (bus.store_valid !== 1'b0 || bus.store_id !== '0 || bus.retired_cnt !== 0) begin
            n_fail++;
            $display("FAIL rstw_out got=%0b/%0d/%0d want=0/0/0", bus.store_valid, bus.store_id,
                     bus.retired_cnt);
        end
        if (bus.commit_valid !== 1'b0 || bus.reset_out !== 1'b0 || bus.halted !== 1'b0) begin
            n_fail++; $display("FAIL rstw_strobes got=%0b/%0b/%0b want=0/0/0",
                               bus.commit_valid, bus.reset_out, bus.halted);
        end
        bus.store_done = 1;
        #1;
        n_cmp++;
        if (bus.pop_head !== 1'b0) begin
            n_fail++; $display("FAIL rstw_done_ignored got=%0b want=0", bus.pop_head);
        end
        tick();
        n_cmp++;
        if (bus.retired_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rstw_cnt got=%0d want=0", bus.retired_cnt);
        end
        bus.store_done = 0;
    endtask

    task automatic test_halt();
        logic [31:0] c0;
        c0 = bus.retired_cnt;
        set_head(1, 1, KindHalt, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if (bus.pop_head !== 1'b1) begin
            n_fail++; $display("FAIL halt_pop got=%0b want=1", bus.pop_head);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            set_head(1, 1, KindNormal, 5'd9, 32'h1, 0, 0, 0);
            bus.store_done = 1;
            #1;
            n_cmp += 3;
            if (bus.halted !== 1'b1) begin
                n_fail++; $display("FAIL halt_sticky[%0d] got=%0b want=1", i, bus.halted);
            end
            if (bus.pop_head !== 1'b0) begin
                n_fail++; $display("FAIL halt_nopop[%0d] got=%0b want=0", i, bus.pop_head);
            end
            if (bus.retired_cnt !== c0 + 1) begin
                n_fail++;
                $display("FAIL halt_cnt[%0d] got=%0d want=%0d", i, bus.retired_cnt, c0 + 1);
            end
            tick();
        end
        idle_head();
    endtask

    task automatic test_random();
        kind_e k;
        rst = 1;
        idle_head();
        tick();
        rst = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            k = ($urandom_range(0, 31) == 0) ? KindHalt : kind_e'($urandom_range(0, 2));
            set_head($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, k,
                     5'($urandom_range(0, 31) < 4 ? 0 : $urandom), reg_t'($urandom),
                     $urandom_range(0, 1) == 1, reg_t'($urandom), ls_id_t'($urandom));
            bus.store_done = $urandom_range(0, 9) < 3;
            rst = ($urandom_range(0, 199) == 0) || (e_halted && $urandom_range(0, 9) == 0);
            #1;
            n_cmp++;
            if (bus.pop_head !== model_pop()) begin
                n_fail++; $display("FAIL rnd_pop cyc=%0d got=%0b want=%0b", cyc, bus.pop_head,
                                   model_pop());
            end
            tick();
            n_cmp++;
            if (bus.commit_valid !== e_cv || bus.commit_rd !== e_rd ||
                bus.commit_value !== e_val || bus.commit_rob_id !== e_rid ||
                bus.reset_out !== e_ro || bus.pc_out !== e_pc || bus.store_valid !== e_sv ||
                bus.store_id !== e_sid || bus.halted !== e_halted || bus.retired_cnt !== m_cnt)
            begin
                n_fail++;
                $display("FAIL rnd_out cyc=%0d got cv%0b rd%0d v%0h id%0d ro%0b pc%0h sv%0b sid%0d h%0b c%0d want cv%0b rd%0d v%0h id%0d ro%0b pc%0h sv%0b sid%0d h%0b c%0d",
                         cyc, bus.commit_valid, bus.commit_rd, bus.commit_value,
                         bus.commit_rob_id, bus.reset_out, bus.pc_out, bus.store_valid,
                         bus.store_id, bus.halted, bus.retired_cnt, e_cv, e_rd, e_val, e_rid,
                         e_ro, e_pc, e_sv, e_sid, e_halted, m_cnt);
            end
        end
        rst = 0;
        idle_head();
    endtask

    initial begin
        rst = 1;
        idle_head();
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_rd_zero();
        test_mispredict();
        test_store();
        test_reset_in_wait();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
